gb_out_stream_checker: RTL
==========================

Name: gb_out_stream_checker

Overview:
- Output-side consumer for the Gaussian-blur ILA-vs-HLS equivalence setup.
- Receives both designs' arg_0 AXI-stream pixel outputs and drives the single shared arg_0_TREADY back to them.
- Buffers each side independently, because the two designs emit pixels on different cycles, then compares pixels in order.
- Reports match count, first mismatch (data and index), stall timeout and completion.

Parameters:
DATA_W, 8, pixel width
CNT_W, 19, width of pixel index/count (matches p_cnt)
FIFO_DEPTH, 4, entries per side FIFO; power of two, >=2
NUM_PIXELS, 1024, pixels to compare before DONE; 1..2^CNT_W-1
TIMEOUT, 64, max cycles one side may lead the other; >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset
start  in  1  begin/restart a compare run (single-cycle pulse)
ila_arg_0_TDATA  in  DATA_W  ILA output pixel
ila_arg_0_TVALID  in  1  ILA pixel valid
hls_arg_0_TDATA  in  DATA_W  HLS output pixel
hls_arg_0_TVALID  in  1  HLS pixel valid
arg_0_TREADY  out  1  shared ready to both designs
cmp_cnt  out  CNT_W  pixels compared and matched
mismatch  out  1  sticky: data mismatch found
mis_index  out  CNT_W  index of first mismatching pixel
mis_ila_data  out  DATA_W  ILA pixel at first mismatch
mis_hls_data  out  DATA_W  HLS pixel at first mismatch
stall_err  out  1  sticky: one side led by TIMEOUT cycles
done  out  1  NUM_PIXELS matched, no error

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, applied at any time including mid-run, takes effect at the next posedge:
  - state=IDLE
  - both FIFOs empty
  - cmp_cnt, mis_index, mis_ila_data, mis_hls_data, stall counter = 0
  - mismatch, stall_err, done = 0
  - arg_0_TREADY = 0
- States: IDLE, RUN, DONE, FAIL.
  - IDLE -> RUN on start.
  - RUN -> DONE on the final matching compare.
  - RUN -> FAIL on mismatch or stall timeout.
  - DONE/FAIL -> RUN on start. Restart first clears FIFOs, counters and flags in that same cycle.
  - start while in RUN is ignored.
- arg_0_TREADY = (state==RUN) && ila_count<FIFO_DEPTH && hls_count<FIFO_DEPTH.
  - Combinational from registered state and counts only; no dependence on TVALID.
  - A same-cycle pop does not lift a full condition; ready stays 0 that cycle.
- Push: a side's FIFO pushes its TDATA on a cycle where its TVALID && arg_0_TREADY. Each side is independent, so zero, one or both may push in a cycle.
- Compare, in RUN when both FIFOs are non-empty at the start of a cycle:
  - Pop both heads that cycle, one compare per cycle max.
  - Push and pop in the same cycle are permitted. Counts update by +push-pop, and the head is read before the write.
- Equal heads:
  - cmp_cnt increments.
  - If the new value == NUM_PIXELS: done=1 and state=DONE next cycle.
- Unequal heads:
  - mismatch=1, mis_index=cmp_cnt (pre-increment), mis_ila_data/mis_hls_data = heads.
  - state=FAIL; cmp_cnt does not increment.
- Stall counter, in RUN:
  - Increments on cycles where exactly one FIFO is non-empty and no compare occurs.
  - Clears to 0 on any compare or when both FIFOs are empty.
  - On reaching TIMEOUT: stall_err=1, state=FAIL.
  - If timeout and compare coincide, the compare wins and the counter clears.
- In DONE/FAIL:
  - TREADY=0; FIFOs are frozen.
  - Flags, mis_* and cmp_cnt hold until start or rst.
- Latency: the first compare occurs 1 cycle after both sides' first accepted beats, i.e. a beat accepted at edge N is compared at edge N+1.
- Arithmetic: cmp_cnt never wraps; DONE is reached first. FIFO pointers wrap modulo FIFO_DEPTH.
- done and mismatch/stall_err are never both 1.

Test Plan:
1. NUM_PIXELS=8, both sides send 0x10..0x17 with identical valids -> cmp_cnt reaches 8, done=1, mismatch=0, TREADY=0 after DONE.
2. HLS lags ILA by 3 cycles, same data, FIFO_DEPTH=4 -> no error; TREADY drops whenever the ILA FIFO holds 4; done after 8 compares.
3. Pixel 5 differs (ILA 0x2A, HLS 0x2B) -> mismatch=1, mis_index=5, mis_ila_data=0x2A, mis_hls_data=0x2B, cmp_cnt=5, state FAIL, done=0.
4. ILA sends 1 pixel, HLS sends none, TIMEOUT=64 -> stall_err=1 exactly 64 cycles after the ILA FIFO becomes non-empty; cmp_cnt=0.
5. rst asserted mid-run after 3 compares, then start -> all outputs 0 after the rst edge; the new run counts from 0 and completes normally.
6. Both TVALID held high with both FIFOs full and compares draining -> no beat is lost or duplicated; a sequence of 0x00..0x07 is compared in order and reaches done.

Source files
------------

// File: rtl/gb_out_stream_checker_if.sv
// Paired arg_0 pixel streams from the ILA and HLS designs with their single shared ready.
// The master drives both TDATA/TVALID pairs; the slave (checker) drives TREADY.
interface gb_out_stream_checker_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] ila_arg_0_TDATA;
    logic              ila_arg_0_TVALID;
    logic [DATA_W-1:0] hls_arg_0_TDATA;
    logic              hls_arg_0_TVALID;
    logic              arg_0_TREADY;

    modport master (
        output ila_arg_0_TDATA, ila_arg_0_TVALID, hls_arg_0_TDATA, hls_arg_0_TVALID,
        input  arg_0_TREADY
    );

    modport slave (
        input  ila_arg_0_TDATA, ila_arg_0_TVALID, hls_arg_0_TDATA, hls_arg_0_TVALID,
        output arg_0_TREADY
    );
endinterface

// File: rtl/gb_out_stream_checker.sv
// Buffers ILA/HLS pixels per side and compares them in order; a pair accepted at edge N is compared at edge N+1.
// Backpressure: shared TREADY drops whenever either side FIFO is full or the run is not active.
module gb_out_stream_checker #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_PIXELS = 1024,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    gb_out_stream_checker_if.slave s_axis,
    output logic [CNT_W-1:0]     cmp_cnt,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     mis_index,
    output logic [DATA_W-1:0]    mis_ila_data,
    output logic [DATA_W-1:0]    mis_hls_data,
    output logic                 stall_err,
    output logic                 done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int STL_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LP_NUM     = CNT_W'(NUM_PIXELS);
    localparam logic [OCC_W-1:0] LP_DEPTH   = OCC_W'(FIFO_DEPTH);
    localparam logic [STL_W-1:0] LP_TIMEOUT = STL_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_ila_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_hls_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_ila_wp, r_ila_rp, r_hls_wp, r_hls_rp;
    logic [OCC_W-1:0]  r_ila_cnt, r_hls_cnt;
    logic [STL_W-1:0]  r_stall;
    logic [CNT_W-1:0]  r_cmp_cnt, r_mis_index;
    logic [DATA_W-1:0] r_mis_ila, r_mis_hls;
    logic              r_mismatch, r_stall_err, r_done;

    logic              w_run, w_ready, w_ila_push, w_hls_push, w_cmp, w_eq, w_clear;
    logic [DATA_W-1:0] w_ila_head, w_hls_head;
    logic [CNT_W-1:0]  w_cmp_next;
    logic [STL_W-1:0]  w_stall_next;

    // Ready looks only at registered occupancy, so a same-cycle pop never reopens a full side.
    assign w_run        = (r_state == S_RUN);
    assign w_ready      = w_run && (r_ila_cnt < LP_DEPTH) && (r_hls_cnt < LP_DEPTH);
    assign w_ila_push   = s_axis.ila_arg_0_TVALID && w_ready;
    assign w_hls_push   = s_axis.hls_arg_0_TVALID && w_ready;
    assign w_cmp        = w_run && (r_ila_cnt != '0) && (r_hls_cnt != '0);
    assign w_ila_head   = r_ila_mem[r_ila_rp];
    assign w_hls_head   = r_hls_mem[r_hls_rp];
    assign w_eq         = (w_ila_head == w_hls_head);
    assign w_cmp_next   = r_cmp_cnt + CNT_W'(1);
    assign w_stall_next = r_stall + STL_W'(1);
    assign w_clear      = rst || (start && !w_run);

    always_ff @(posedge clk) begin
        if (w_ila_push) r_ila_mem[r_ila_wp] <= s_axis.ila_arg_0_TDATA;
        if (w_hls_push) r_hls_mem[r_hls_wp] <= s_axis.hls_arg_0_TDATA;
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state     <= rst ? S_IDLE : S_RUN;
            r_ila_wp    <= '0;
            r_ila_rp    <= '0;
            r_hls_wp    <= '0;
            r_hls_rp    <= '0;
            r_ila_cnt   <= '0;
            r_hls_cnt   <= '0;
            r_stall     <= '0;
            r_cmp_cnt   <= '0;
            r_mis_index <= '0;
            r_mis_ila   <= '0;
            r_mis_hls   <= '0;
            r_mismatch  <= 1'b0;
            r_stall_err <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_run) begin
            if (w_ila_push) r_ila_wp <= r_ila_wp + PTR_W'(1);
            if (w_hls_push) r_hls_wp <= r_hls_wp + PTR_W'(1);
            if (w_cmp) begin
                r_ila_rp <= r_ila_rp + PTR_W'(1);
                r_hls_rp <= r_hls_rp + PTR_W'(1);
            end
            r_ila_cnt <= r_ila_cnt + OCC_W'(w_ila_push) - OCC_W'(w_cmp);
            r_hls_cnt <= r_hls_cnt + OCC_W'(w_hls_push) - OCC_W'(w_cmp);

            // A compare always clears the stall count, even on the cycle it would have timed out.
            if (w_cmp) begin
                r_stall <= '0;
                if (w_eq) begin
                    r_cmp_cnt <= w_cmp_next;
                    if (w_cmp_next == LP_NUM) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end else begin
                    r_mismatch  <= 1'b1;
                    r_mis_index <= r_cmp_cnt;
                    r_mis_ila   <= w_ila_head;
                    r_mis_hls   <= w_hls_head;
                    r_state     <= S_FAIL;
                end
            end else if ((r_ila_cnt == '0) && (r_hls_cnt == '0)) begin
                r_stall <= '0;
            end else begin
                r_stall <= w_stall_next;
                if (w_stall_next == LP_TIMEOUT) begin
                    r_stall_err <= 1'b1;
                    r_state     <= S_FAIL;
                end
            end
        end
    end

    assign s_axis.arg_0_TREADY = w_ready;
    assign cmp_cnt      = r_cmp_cnt;
    assign mismatch     = r_mismatch;
    assign mis_index    = r_mis_index;
    assign mis_ila_data = r_mis_ila;
    assign mis_hls_data = r_mis_hls;
    assign stall_err    = r_stall_err;
    assign done         = r_done;
endmodule
